// File: rtl/noc_arb_requester.sv
// Requester front end for one round-robin arbiter port: flit FIFO plus an
// IDLE/REQ/SEND controller that holds req for a whole packet.
module noc_arb_requester #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_head,
  input  logic              in_tail,
  output logic              req,
  input  logic              gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_tail,
  output logic              drop_err,
  output logic [15:0]       wait_cycles
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  typedef struct packed {
    logic              head;
    logic              tail;
    logic [DATA_W-1:0] data;
  } flit_t;

  flit_t       mem [DEPTH];
  flit_t       front;
  logic [AW:0] wptr, rptr;
  logic [1:0]  state;
  logic        full, empty, push, pop, discard;

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign front     = mem[rptr[AW-1:0]];
  assign out_data  = front.data;
  assign out_tail  = front.tail;
  // Headless flits at the front while idle are orphans; drop them so a
  // stray body flit can never wedge the port.
  assign discard   = (state == IDLE) && !empty && !front.head;
  assign out_valid = (state == SEND) && !empty && gnt;
  assign pop       = (out_valid && out_ready) || discard;

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{head: in_head, tail: in_tail, data: in_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      req         <= 1'b0;
      drop_err    <= 1'b0;
      wait_cycles <= '0;
    end else begin
      drop_err <= discard;
      case (state)
        IDLE: if (!empty && front.head) begin
          state       <= REQ;
          req         <= 1'b1;
          wait_cycles <= '0;
        end
        REQ: begin
          if (gnt) state <= SEND;
          else if (wait_cycles != 16'hFFFF) wait_cycles <= wait_cycles + 16'd1;
        end
        // req drops on the tail edge, guaranteeing one low cycle for rotation
        SEND: if (pop && front.tail) begin
          state <= IDLE;
          req   <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_noc_arb_requester.sv
// Directed bench for noc_arb_requester; a scoreboard queue holds the flits
// expected at the output, in order, and a negedge monitor retires them.
module tb_noc_arb_requester;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_head, in_tail;
  logic [31:0] in_data;
  logic        req, gnt, out_valid, out_ready, out_tail, drop_err;
  logic [31:0] out_data;
  logic [15:0] wait_cycles;

  typedef struct packed {
    logic        tail;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   nxfer = 0;

  noc_arb_requester #(.DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_head(in_head), .in_tail(in_tail),
    .req(req), .gnt(gnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tail(out_tail),
    .drop_err(drop_err), .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the active edge and hold until the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic h, input logic t, input logic [31:0] d);
    in_valid = v;
    in_head  = h;
    in_tail  = t;
    in_data  = d;
  endtask

  task automatic expect_flit(input logic t, input logic [31:0] d);
    sb.push_back({t, d});
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("xfer_unexpected", {32'd0, out_data}, 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("xfer_data", {32'd0, out_data}, {32'd0, e.data});
        chk("xfer_tail", {63'd0, out_tail}, {63'd0, e.tail});
        nxfer++;
      end
    end
  end

  initial begin
    int n0;
    rst = 1'b0; gnt = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 32'h0);
    #3;
    chk("rst_req",       {63'd0, req},       64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_wait",      {48'd0, wait_cycles}, 64'd0);
    chk("rst_drop",      {63'd0, drop_err},  64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single-flit packet, grant arrives after 3 ungranted REQ cycles
    drive(1, 1, 1, 32'hA5A5A5A5); expect_flit(1, 32'hA5A5A5A5);
    tick();                                   // E0 push
    drive(0, 0, 0, 32'h0);
    @(negedge clk); chk("a_req_e0", {63'd0, req}, 64'd0);
    tick();                                   // E1 -> REQ
    @(negedge clk); chk("a_req_e1", {63'd0, req}, 64'd1);
    chk("a_wait_clr", {48'd0, wait_cycles}, 64'd0);
    tick(); tick(); tick();                   // E2..E4 count waits
    gnt = 1'b1; out_ready = 1'b1;
    @(negedge clk); chk("a_wait3", {48'd0, wait_cycles}, 64'd3);
    chk("a_ov_req", {63'd0, out_valid}, 64'd0);
    n0 = nxfer;
    tick();                                   // E5 -> SEND
    @(negedge clk); chk("a_ov_send", {63'd0, out_valid}, 64'd1);
    tick();                                   // E6 tail popped
    gnt = 1'b0;
    @(negedge clk); chk("a_req_rel", {63'd0, req}, 64'd0);
    chk("a_ov_idle", {63'd0, out_valid}, 64'd0);
    chk("a_wait_hold", {48'd0, wait_cycles}, 64'd3);
    chk("a_nxfer", nxfer - n0, 64'd1);

    // 4-flit packet, grant tied high, flits stream back to back
    tick();
    gnt = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_flit(i == 3, 32'h1000 + i);
    drive(1, 1, 0, 32'h1000); tick();         // E0
    drive(1, 0, 0, 32'h1001);
    @(negedge clk); chk("b_req_e0", {63'd0, req}, 64'd0);
    tick();                                   // E1 -> REQ
    drive(1, 0, 0, 32'h1002);
    @(negedge clk); chk("b_req_e1", {63'd0, req}, 64'd1);
    tick();                                   // E2 -> SEND
    drive(1, 0, 1, 32'h1003);
    n0 = nxfer;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("b_stream_ov", {63'd0, out_valid}, 64'd1);
      tick();
      drive(0, 0, 0, 32'h0);
    end
    @(negedge clk); chk("b_req_rel", {63'd0, req}, 64'd0);
    chk("b_nxfer", nxfer - n0, 64'd4);
    chk("b_wait0", {48'd0, wait_cycles}, 64'd0);

    // 4-flit packet, grant drops for 2 cycles after the first flit
    tick();
    gnt = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_flit(i == 3, 32'h2000 + i);
      drive(1, i == 0, i == 3, 32'h2000 + i);
      tick();                                 // E0..E3
    end
    drive(0, 0, 0, 32'h0);
    gnt = 1'b1;
    chk("c_wait2", {48'd0, wait_cycles}, 64'd2);
    n0 = nxfer;
    tick();                                   // E4 -> SEND
    @(negedge clk); chk("c_ov_f1", {63'd0, out_valid}, 64'd1);
    tick();                                   // E5 pops flit 1
    gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("c_stall_ov",  {63'd0, out_valid}, 64'd0);
      chk("c_stall_req", {63'd0, req},       64'd1);
      tick();
    end
    gnt = 1'b1;
    chk("c_nxfer_stall", nxfer - n0, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("c_resume_ov", {63'd0, out_valid}, 64'd1);
      tick();
    end
    @(negedge clk); chk("c_req_rel", {63'd0, req}, 64'd0);
    chk("c_nxfer", nxfer - n0, 64'd4);

    // Non-head flit while idle is discarded
    tick();
    drive(1, 0, 1, 32'hBAD0BAD0); tick();     // E0 push
    drive(0, 0, 0, 32'h0);
    @(negedge clk); chk("d_drop_e0", {63'd0, drop_err}, 64'd0);
    tick();                                   // E1 discard
    @(negedge clk); chk("d_drop_pulse", {63'd0, drop_err}, 64'd1);
    chk("d_req_low", {63'd0, req}, 64'd0);
    tick();
    @(negedge clk); chk("d_drop_clr", {63'd0, drop_err}, 64'd0);
    tick();
    @(negedge clk); chk("d_req_still_low", {63'd0, req}, 64'd0);
    chk("d_in_ready", {63'd0, in_ready}, 64'd1);

    // Fill to full with out_ready low; fifth flit must be held off
    tick();
    gnt = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) expect_flit(i >= 3, 32'h3000 + i);
    for (int i = 0; i < 4; i++) begin
      drive(1, i == 0, i == 3, 32'h3000 + i);
      @(negedge clk); chk("e_fill_ready", {63'd0, in_ready}, 64'd1);
      tick();                                 // E0..E3
    end
    drive(1, 1, 1, 32'h3004);
    @(negedge clk); chk("e_full", {63'd0, in_ready}, 64'd0);
    tick();                                   // E4, held
    gnt = 1'b1; out_ready = 1'b1;
    @(negedge clk); chk("e_full_hold", {63'd0, in_ready}, 64'd0);
    tick();                                   // E5 -> SEND
    @(negedge clk); chk("e_full_send", {63'd0, in_ready}, 64'd0);
    tick();                                   // E6 first pop
    @(negedge clk); chk("e_ready_after_pop", {63'd0, in_ready}, 64'd1);
    tick();                                   // E7 fifth flit accepted
    drive(0, 0, 0, 32'h0);
    for (int i = 0; i < 20 && !(sb.size() == 0 && req === 1'b0); i++) tick();
    chk("e_drain", sb.size(), 64'd0);

    // Asynchronous reset mid-packet with 2 flits buffered
    tick();
    gnt = 1'b0; out_ready = 1'b0;
    drive(1, 1, 0, 32'h4000); tick();         // E0
    drive(1, 0, 1, 32'h4001); tick();         // E1 -> REQ
    drive(0, 0, 0, 32'h0);
    tick();                                   // E2 wait=1
    gnt = 1'b1;
    tick();                                   // E3 -> SEND
    @(negedge clk);
    chk("f_pre_req", {63'd0, req}, 64'd1);
    chk("f_pre_ov",  {63'd0, out_valid}, 64'd1);
    chk("f_pre_wait", {48'd0, wait_cycles}, 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("f_rst_req",      {63'd0, req},       64'd0);
    chk("f_rst_ov",       {63'd0, out_valid}, 64'd0);
    chk("f_rst_in_ready", {63'd0, in_ready},  64'd1);
    chk("f_rst_wait",     {48'd0, wait_cycles}, 64'd0);
    tick();
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("f_flushed_req", {63'd0, req}, 64'd0);
    chk("f_flushed_ov",  {63'd0, out_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
